// File: rtl/alu_ctr_gen.sv
// RV32I ALU control decoder behind a one-entry output register plus skid buffer.
// Illegal encodings flow through flagged, with a saturating count of accepted illegal words.
module alu_ctr_gen (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  aluctr,
   output logic        alu_asrc,
   output logic [1:0]  alu_bsrc,
   output logic [2:0]  ext_op,
   output logic        illegal,
   output logic [7:0]  illegal_cnt
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [3:0]  d_alu;
   logic        d_asrc;
   logic [1:0]  d_bsrc;
   logic [2:0]  d_ext;
   logic        d_ill;
   logic [10:0] dec;

   logic [10:0] out_q;
   logic [10:0] skid_q;
   logic        skid_valid;
   logic        in_xfer;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   always_comb begin
      d_alu  = 4'b0000;
      d_asrc = 1'b0;
      d_bsrc = 2'b00;
      d_ext  = 3'b000;
      d_ill  = 1'b0;
      case (opcode)
         7'b0110111: begin
            d_alu  = 4'b1111;
            d_bsrc = 2'b01;
            d_ext  = 3'b001;
         end
         7'b0010111: begin
            d_asrc = 1'b1;
            d_bsrc = 2'b01;
            d_ext  = 3'b001;
         end
         7'b1101111: begin
            d_asrc = 1'b1;
            d_bsrc = 2'b10;
            d_ext  = 3'b100;
         end
         7'b1100111: begin
            d_asrc = 1'b1;
            d_bsrc = 2'b10;
            d_ill  = (funct3 != 3'b000);
         end
         7'b1100011: begin
            d_ext = 3'b011;
            case (funct3)
               3'b000, 3'b001: d_alu = 4'b1000;
               3'b100, 3'b101: d_alu = 4'b0010;
               3'b110, 3'b111: d_alu = 4'b0011;
               default:        d_ill = 1'b1;
            endcase
         end
         7'b0000011: begin
            d_bsrc = 2'b01;
            d_ill  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         7'b0100011: begin
            d_bsrc = 2'b01;
            d_ext  = 3'b010;
            d_ill  = (funct3[2] == 1'b1) || (funct3 == 3'b011);
         end
         7'b0010011: begin
            d_bsrc = 2'b01;
            d_alu  = {1'b0, funct3};
            if (funct3 == 3'b001 && funct7 != 7'b0000000)
               d_ill = 1'b1;
            if (funct3 == 3'b101) begin
               if (funct7 == 7'b0100000)
                  d_alu = 4'b1101;
               else if (funct7 != 7'b0000000)
                  d_ill = 1'b1;
            end
         end
         7'b0110011: begin
            if (funct7 == 7'b0000000)
               d_alu = {1'b0, funct3};
            else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
               d_alu = {1'b1, funct3};
            else
               d_ill = 1'b1;
         end
         default: d_ill = 1'b1;
      endcase
      // illegal words leave the stage with every control field zeroed
      if (d_ill) begin
         d_alu  = 4'b0000;
         d_asrc = 1'b0;
         d_bsrc = 2'b00;
         d_ext  = 3'b000;
      end
   end

   assign dec     = {d_ill, d_alu, d_asrc, d_bsrc, d_ext};
   assign in_xfer = in_valid && in_ready;

   // in_ready comes straight from the skid flop, so it is registered by construction
   assign in_ready = !skid_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_q      <= '0;
         skid_valid <= 1'b0;
         skid_q     <= '0;
      end else if (!out_valid || out_ready) begin
         if (skid_valid) begin
            out_q      <= skid_q;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else if (in_xfer) begin
            out_q     <= dec;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (in_xfer) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         illegal_cnt <= 8'd0;
      else if (in_xfer && d_ill && illegal_cnt != 8'hFF)
         illegal_cnt <= illegal_cnt + 8'd1;
   end

   assign illegal  = out_q[10];
   assign aluctr   = out_q[9:6];
   assign alu_asrc = out_q[5];
   assign alu_bsrc = out_q[4:3];
   assign ext_op   = out_q[2:0];

endmodule

// File: tb/tb_alu_ctr_gen.sv
// Directed and streaming checks for alu_ctr_gen against an independent decode table.
module tb_alu_ctr_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  aluctr;
   logic        alu_asrc;
   logic [1:0]  alu_bsrc;
   logic [2:0]  ext_op;
   logic        illegal;
   logic [7:0]  illegal_cnt;

   int n_vec = 0;
   int n_err = 0;

   alu_ctr_gen dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .out_valid(out_valid), .out_ready(out_ready), .aluctr(aluctr), .alu_asrc(alu_asrc),
      .alu_bsrc(alu_bsrc), .ext_op(ext_op), .illegal(illegal), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [10:0] cur();
      return {illegal, aluctr, alu_asrc, alu_bsrc, ext_op};
   endfunction

   // reference decode: {illegal, aluctr, asrc, bsrc, ext}
   function automatic logic [10:0] ref_dec(input logic [31:0] w);
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [10:0] ill;
      f3  = w[14:12];
      f7  = w[31:25];
      ill = 11'b100_0000_0000;
      case (w[6:0])
         7'h37: return {1'b0, 4'hF, 1'b0, 2'b01, 3'd1};
         7'h17: return {1'b0, 4'h0, 1'b1, 2'b01, 3'd1};
         7'h6F: return {1'b0, 4'h0, 1'b1, 2'b10, 3'd4};
         7'h67: return (f3 == 3'd0) ? {1'b0, 4'h0, 1'b1, 2'b10, 3'd0} : ill;
         7'h63: begin
            if (f3 == 3'd0 || f3 == 3'd1) return {1'b0, 4'h8, 1'b0, 2'b00, 3'd3};
            if (f3 == 3'd4 || f3 == 3'd5) return {1'b0, 4'h2, 1'b0, 2'b00, 3'd3};
            if (f3 == 3'd6 || f3 == 3'd7) return {1'b0, 4'h3, 1'b0, 2'b00, 3'd3};
            return ill;
         end
         7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? {1'b0, 4'h0, 1'b0, 2'b01, 3'd0} : ill;
         7'h23: return (f3 inside {3'd0, 3'd1, 3'd2}) ? {1'b0, 4'h0, 1'b0, 2'b01, 3'd2} : ill;
         7'h13: begin
            if (f3 == 3'd1 && f7 != 7'h00) return ill;
            if (f3 == 3'd5 && f7 == 7'h20) return {1'b0, 4'hD, 1'b0, 2'b01, 3'd0};
            if (f3 == 3'd5 && f7 != 7'h00) return ill;
            return {1'b0, 1'b0, f3, 1'b0, 2'b01, 3'd0};
         end
         7'h33: begin
            if (f7 == 7'h00) return {1'b0, 1'b0, f3, 1'b0, 2'b00, 3'd0};
            if (f7 == 7'h20 && f3 == 3'd0) return {1'b0, 4'h8, 1'b0, 2'b00, 3'd0};
            if (f7 == 7'h20 && f3 == 3'd5) return {1'b0, 4'hD, 1'b0, 2'b00, 3'd0};
            return ill;
         end
         default: return ill;
      endcase
   endfunction

   function automatic logic [31:0] gen_word();
      logic [31:0] w;
      logic [6:0]  ops [9];
      int          k;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
      w = $urandom;
      k = $urandom_range(0, 11);
      if (k < 9) w[6:0] = ops[k];
      if (k == 7 || k == 8) begin
         if ($urandom_range(0, 1) == 1) w[31:25] = 7'h00;
         else if ($urandom_range(0, 1) == 1) w[31:25] = 7'h20;
      end
      return w;
   endfunction

   logic [31:0] dv_instr [15];
   logic [10:0] dv_exp   [15];

   initial begin
      dv_instr = '{32'h40B50533, 32'h4055D513, 32'h0000E063, 32'h00500093, 32'h0002A303,
                   32'h0062A023, 32'h00001117, 32'h000080E7, 32'h4050D533, 32'h0020A033,
                   32'h00000000, 32'h02009093, 32'h4000C033, 32'h00002063, 32'h40B50532};
      dv_exp   = '{{1'b0, 4'b1000, 1'b0, 2'b00, 3'b000},
                   {1'b0, 4'b1101, 1'b0, 2'b01, 3'b000},
                   {1'b0, 4'b0011, 1'b0, 2'b00, 3'b011},
                   {1'b0, 4'b0000, 1'b0, 2'b01, 3'b000},
                   {1'b0, 4'b0000, 1'b0, 2'b01, 3'b000},
                   {1'b0, 4'b0000, 1'b0, 2'b01, 3'b010},
                   {1'b0, 4'b0000, 1'b1, 2'b01, 3'b001},
                   {1'b0, 4'b0000, 1'b1, 2'b10, 3'b000},
                   {1'b0, 4'b1101, 1'b0, 2'b00, 3'b000},
                   {1'b0, 4'b0010, 1'b0, 2'b00, 3'b000},
                   11'b100_0000_0000, 11'b100_0000_0000, 11'b100_0000_0000,
                   11'b100_0000_0000, 11'b100_0000_0000};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      instr     = 32'h0;
      out_ready = 1'b1;
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_fields", 32'(cur()), 32'd0);
      chk("rst_cnt", 32'(illegal_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // directed single words
      for (int i = 0; i < 15; i++) begin
         in_valid = 1'b1;
         instr    = dv_instr[i];
         tick();
         in_valid = 1'b0;
         chk($sformatf("dir%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("dir%0d_%h", i, dv_instr[i]), 32'(cur()), 32'(dv_exp[i]));
         chk($sformatf("ref%0d", i), 32'(ref_dec(dv_instr[i])), 32'(dv_exp[i]));
         tick();
      end
      chk("cnt_after_dir", 32'(illegal_cnt), 32'd5);
      chk("idle_valid", 32'(out_valid), 32'd0);

      // back-to-back under backpressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr     = 32'h12345537;
      tick();
      instr     = 32'h008000EF;
      tick();
      in_valid  = 1'b0;
      chk("bb_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bb_hold", 32'({out_valid, cur()}), 32'({1'b1, 1'b0, 4'b1111, 1'b0, 2'b01, 3'b001}));
      end
      out_ready = 1'b1;
      tick();
      chk("bb_second", 32'({out_valid, cur()}), 32'({1'b1, 1'b0, 4'b0000, 1'b1, 2'b10, 3'b100}));
      chk("bb_ready_back", 32'(in_ready), 32'd1);
      tick();
      chk("bb_drained", 32'(out_valid), 32'd0);

      // reset while skid is full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr     = 32'h40B50533;
      tick();
      instr     = 32'h00000000;
      tick();
      in_valid  = 1'b0;
      chk("pre_rst_full", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_fields", 32'(cur()), 32'd0);
      chk("arst_cnt", 32'(illegal_cnt), 32'd0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("arst_no_stale", 32'(out_valid), 32'd0);
      end

      // acceptance on the first edge after release
      #2;
      rst_n = 1'b0;
      tick();
      rst_n    = 1'b1;
      in_valid = 1'b1;
      instr    = 32'h40B50533;
      tick();
      in_valid = 1'b0;
      chk("first_edge", 32'({out_valid, cur()}), 32'({1'b1, 1'b0, 4'b1000, 1'b0, 2'b00, 3'b000}));
      tick();

      // saturating illegal counter
      in_valid = 1'b1;
      instr    = 32'h00000000;
      for (int i = 0; i < 300; i++) begin
         tick();
         chk("ill_out", 32'({out_valid, illegal}), 32'd3);
         if (i == 253) chk("cnt_254", 32'(illegal_cnt), 32'd254);
      end
      in_valid = 1'b0;
      tick();
      chk("cnt_sat", 32'(illegal_cnt), 32'd255);

      // random stream with random backpressure
      begin
         logic [10:0] q [$];
         logic [11:0] held;
         logic        hold_prev;
         logic        acc;
         int          sent;
         int          got;
         int          cyc;
         sent      = 0;
         got       = 0;
         cyc       = 0;
         hold_prev = 1'b0;
         held      = '0;
         in_valid  = 1'b1;
         instr     = gen_word();
         while (got < 1000 && cyc < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hold_prev) chk("stall_hold", 32'({out_valid, cur()}), 32'(held));
            acc = in_valid && in_ready;
            if (acc) q.push_back(ref_dec(instr));
            if (out_valid && out_ready) begin
               if (q.size() == 0) chk("extra_out", 32'(cur()), 32'h7FF);
               else chk($sformatf("stream%0d", got), 32'(cur()), 32'(q.pop_front()));
               got++;
            end
            hold_prev = out_valid && !out_ready;
            held      = {out_valid, cur()};
            @(posedge clk);
            #1;
            if (acc) begin
               sent++;
               if (sent < 1000) instr = gen_word();
               else in_valid = 1'b0;
            end
            cyc++;
         end
         chk("stream_count", 32'(got), 32'd1000);
         chk("stream_left", 32'(q.size()), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
